donkey_motion_ctrl: RTL and testbench

Motion sequencer for the Donkey character. It converts player direction/jump requests into pixel-step updates of the character's X/Y position. Horizontal moves and jump steps are paced by two independent tick dividers, and a state machine sequences each jump. Its outputs drive the Donkey sprite position consumed by the draw pipeline. Floor is a single fixed ground line (no platform collision in this block).

---
 rtl/donkey_motion_ctrl.sv | 157 +++++++++++++++
 tb/tb_donkey_motion_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/donkey_motion_ctrl.sv
// Donkey character motion sequencer: paced horizontal steps plus a
// three-state jump sequencer driving the sprite's top-left position.
module donkey_motion_ctrl #(
   parameter int unsigned MOVE_PERIOD = 250_000,
   parameter int unsigned JUMP_PERIOD = 24_137,
   parameter int unsigned JUMP_HEIGHT = 58,
   parameter int unsigned INIT_X      = 128,
   parameter int unsigned GROUND_Y    = 672,
   parameter int unsigned X_MIN       = 0,
   parameter int unsigned X_MAX       = 976
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        restart,
   input  logic        left,
   input  logic        right,
   input  logic        jump,
   output logic [10:0] xpos,
   output logic [10:0] ypos,
   output logic        jumping,
   output logic        facing_left
);

   localparam int unsigned POS_W   = 11;
   localparam int unsigned MOVE_CW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
   localparam int unsigned JUMP_CW = (JUMP_PERIOD > 1) ? $clog2(JUMP_PERIOD) : 1;
   localparam int unsigned HGT_W   = (JUMP_HEIGHT > 0) ? $clog2(JUMP_HEIGHT + 1) : 1;

   localparam logic [MOVE_CW-1:0] MOVE_LAST = MOVE_CW'(MOVE_PERIOD - 1);
   localparam logic [JUMP_CW-1:0] JUMP_LAST = JUMP_CW'(JUMP_PERIOD - 1);
   localparam logic [HGT_W-1:0]   HGT_TOP   = HGT_W'(JUMP_HEIGHT);
   localparam logic [POS_W-1:0]   X_INIT    = POS_W'(INIT_X);
   localparam logic [POS_W-1:0]   X_LO      = POS_W'(X_MIN);
   localparam logic [POS_W-1:0]   X_HI      = POS_W'(X_MAX);
   localparam logic [POS_W-1:0]   Y_GROUND  = POS_W'(GROUND_Y);
   localparam logic [POS_W-1:0]   Y_APEX    = POS_W'(GROUND_Y - JUMP_HEIGHT);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_UP   = 2'd1;
   localparam logic [1:0] ST_DOWN = 2'd2;

   logic [1:0]         state_q,    state_d;
   logic [MOVE_CW-1:0] move_cnt_q, move_cnt_d;
   logic [JUMP_CW-1:0] jump_cnt_q, jump_cnt_d;
   logic [HGT_W-1:0]   height_q,   height_d;
   logic [POS_W-1:0]   xpos_q,     xpos_d;
   logic [POS_W-1:0]   ypos_q,     ypos_d;
   logic               jumping_q,  jumping_d;
   logic               facing_q,   facing_d;
   logic               move_tick_c;
   logic               jump_tick_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         move_cnt_q <= '0;
         jump_cnt_q <= '0;
         height_q   <= '0;
         xpos_q     <= X_INIT;
         ypos_q     <= Y_GROUND;
         jumping_q  <= 1'b0;
         facing_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         move_cnt_q <= move_cnt_d;
         jump_cnt_q <= jump_cnt_d;
         height_q   <= height_d;
         xpos_q     <= xpos_d;
         ypos_q     <= ypos_d;
         jumping_q  <= jumping_d;
         facing_q   <= facing_d;
      end
   end

   // Next-state logic: restart overrides enable; disabled cycles hold everything
   always_comb begin
      state_d     = state_q;
      move_cnt_d  = move_cnt_q;
      jump_cnt_d  = jump_cnt_q;
      height_d    = height_q;
      xpos_d      = xpos_q;
      ypos_d      = ypos_q;
      jumping_d   = jumping_q;
      facing_d    = facing_q;
      move_tick_c = 1'b0;
      jump_tick_c = 1'b0;

      if (restart) begin
         state_d    = ST_IDLE;
         move_cnt_d = '0;
         jump_cnt_d = '0;
         height_d   = '0;
         xpos_d     = X_INIT;
         ypos_d     = Y_GROUND;
         jumping_d  = 1'b0;
         facing_d   = 1'b0;
      end else if (enable) begin
         move_tick_c = (move_cnt_q == MOVE_LAST);
         move_cnt_d  = move_tick_c ? '0 : move_cnt_q + MOVE_CW'(1);

         // Facing follows a lone request even when pinned at a limit
         if (move_tick_c) begin
            if (left && !right) begin
               facing_d = 1'b1;
               if (xpos_q > X_LO) xpos_d = xpos_q - POS_W'(1);
            end else if (right && !left) begin
               facing_d = 1'b0;
               if (xpos_q < X_HI) xpos_d = xpos_q + POS_W'(1);
            end
         end

         if (state_q != ST_IDLE) begin
            jump_tick_c = (jump_cnt_q == JUMP_LAST);
            jump_cnt_d  = jump_tick_c ? '0 : jump_cnt_q + JUMP_CW'(1);
         end

         case (state_q)
            ST_IDLE: begin
               if (jump) begin
                  state_d    = ST_UP;
                  jumping_d  = 1'b1;
                  jump_cnt_d = '0;
                  height_d   = '0;
               end
            end
            ST_UP: begin
               if (jump_tick_c) begin
                  if (ypos_q > Y_APEX) ypos_d = ypos_q - POS_W'(1);
                  height_d = height_q + HGT_W'(1);
                  if (height_q + HGT_W'(1) == HGT_TOP) state_d = ST_DOWN;
               end
            end
            ST_DOWN: begin
               if (jump_tick_c) begin
                  if (ypos_q < Y_GROUND) ypos_d = ypos_q + POS_W'(1);
                  if (ypos_q + POS_W'(1) >= Y_GROUND) begin
                     state_d   = ST_IDLE;
                     jumping_d = 1'b0;
                  end
               end
            end
            default: begin
               state_d   = ST_IDLE;
               jumping_d = 1'b0;
            end
         endcase
      end
   end

   assign xpos        = xpos_q;
   assign ypos        = ypos_q;
   assign jumping     = jumping_q;
   assign facing_left = facing_q;

endmodule

// File: tb/tb_donkey_motion_ctrl.sv
// Directed bench for donkey_motion_ctrl with short move/jump periods.
module tb_donkey_motion_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        restart;
   logic        left;
   logic        right;
   logic        jump;
   logic [10:0] xpos;
   logic [10:0] ypos;
   logic        jumping;
   logic        facing_left;

   int checks   = 0;
   int failures = 0;

   donkey_motion_ctrl #(
      .MOVE_PERIOD(4),
      .JUMP_PERIOD(2),
      .JUMP_HEIGHT(5)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .restart     (restart),
      .left        (left),
      .right       (right),
      .jump        (jump),
      .xpos        (xpos),
      .ypos        (ypos),
      .jumping     (jumping),
      .facing_left (facing_left)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [10:0] ex, input logic [10:0] ey,
                          input logic ej, input logic ef);
      chk({tag, ".x"}, xpos, ex);
      chk({tag, ".y"}, ypos, ey);
      chk({tag, ".jump"}, 11'(jumping), 11'(ej));
      chk({tag, ".face"}, 11'(facing_left), 11'(ef));
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; restart = 1'b0;
      left = 1'b0; right = 1'b0; jump = 1'b0;
      tick(2);
      chk_all("reset", 11'd128, 11'd672, 1'b0, 1'b0);

      // Two move ticks, then an asynchronous reset mid-cycle
      rst_n = 1'b1; enable = 1'b1; right = 1'b1;
      tick(8);
      chk("pre_rst.x", xpos, 11'd130);
      #3 rst_n = 1'b0;
      #1;
      chk_all("async_rst", 11'd128, 11'd672, 1'b0, 1'b0);
      tick(1);
      rst_n = 1'b1; right = 1'b0;

      tick(100);
      chk_all("idle100", 11'd128, 11'd672, 1'b0, 1'b0);

      // Horizontal stepping
      right = 1'b1;
      tick(40);
      chk_all("right40", 11'd138, 11'd672, 1'b0, 1'b0);
      left = 1'b1;
      tick(20);
      chk_all("both20", 11'd138, 11'd672, 1'b0, 1'b0);
      right = 1'b0;
      tick(8);
      chk_all("left8", 11'd136, 11'd672, 1'b0, 1'b1);

      // Limits
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      chk_all("restart", 11'd128, 11'd672, 1'b0, 1'b0);
      tick(600);
      chk_all("left_limit", 11'd0, 11'd672, 1'b0, 1'b1);
      left = 1'b0; right = 1'b1;
      tick(4000);
      chk_all("right_limit", 11'd976, 11'd672, 1'b0, 1'b0);
      right = 1'b0;

      // Jump profile with a mid-air jump request
      jump = 1'b1;
      tick(1);
      jump = 1'b0;
      chk_all("jump_start", 11'd976, 11'd672, 1'b1, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         jump = (k == 3);
         tick(2);
         chk($sformatf("up%0d.y", k), ypos, 11'(672 - k));
         chk($sformatf("up%0d.jump", k), 11'(jumping), 11'd1);
      end
      jump = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick(2);
         chk($sformatf("down%0d.y", k), ypos, 11'(667 + k));
         chk($sformatf("down%0d.jump", k), 11'(jumping), (k < 5) ? 11'd1 : 11'd0);
      end

      // Jump combined with movement; ticks coincide on every move tick
      restart = 1'b1;
      tick(1);
      restart = 1'b0; right = 1'b1;
      tick(1);
      jump = 1'b1;
      tick(1);
      chk_all("jm_e2", 11'd128, 11'd672, 1'b1, 1'b0);
      tick(2);
      chk_all("jm_e4", 11'd129, 11'd671, 1'b1, 1'b0);
      tick(4);
      chk_all("jm_e8", 11'd130, 11'd669, 1'b1, 1'b0);
      tick(4);
      chk_all("jm_e12", 11'd131, 11'd667, 1'b1, 1'b0);
      tick(10);
      chk_all("jm_land", 11'd133, 11'd672, 1'b0, 1'b0);
      tick(1);
      chk_all("jm_rejump", 11'd133, 11'd672, 1'b1, 1'b0);
      tick(1);
      chk_all("jm_e24", 11'd134, 11'd672, 1'b1, 1'b0);
      tick(1);
      chk_all("jm_e25", 11'd134, 11'd671, 1'b1, 1'b0);
      jump = 1'b0; right = 1'b0;
      tick(8);
      chk_all("apex2", 11'd134, 11'd667, 1'b1, 1'b0);

      // Freeze at apex with requests that must be ignored
      enable = 1'b0; left = 1'b1; jump = 1'b1;
      tick(50);
      chk_all("frozen", 11'd134, 11'd667, 1'b1, 1'b0);
      restart = 1'b1;
      tick(1);
      restart = 1'b0; left = 1'b0; jump = 1'b0;
      chk_all("restart_frozen", 11'd128, 11'd672, 1'b0, 1'b0);
      enable = 1'b1;
      tick(12);
      chk_all("after_restart", 11'd128, 11'd672, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
